hazard_ctrl: RTL and testbench



---
 rtl/pipeline_pkg.sv | 15 +
 rtl/forwarding_unit.sv | 17 +
 rtl/hazard_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types for the core's hazard and forwarding logic.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/forwarding_unit.sv
// forwarding_unit: selects the EX operand source; the younger MEM result beats WB.
module forwarding_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] rsE,
    input  logic [4:0] rdM,
    input  logic       regWriteM,
    input  logic [4:0] rdW,
    input  logic       regWriteW,
    output fwd_sel_t   fwd
);

    always_comb
        fwd = (regWriteM && rdM != 5'd0 && rdM == rsE) ? FWD_MEM :
              (regWriteW && rdW != 5'd0 && rdW == rsE) ? FWD_WB  : FWD_RF;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forward control with a memory-wait watchdog
// and saturating stall/flush event counters.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic             memReadE,
    input  logic             pcSrcE,
    input  logic [4:0]       rdM,
    input  logic             regWriteM,
    input  logic             memReqM,
    input  logic             memReadyM,
    input  logic [4:0]       rdW,
    input  logic             regWriteW,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushEvents
);

    localparam int WW = $clog2(TIMEOUT + 1);

    hz_state_t     state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_cnt_nxt;
    logic          mem_wait, lw_stall, any_stall, any_flush;
    fwd_sel_t      fwd_a, fwd_b;

    assign mem_wait = memReqM & ~memReadyM;
    assign lw_stall = memReadE & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));

    // Controls are forced quiet while reset is held, independent of the inputs.
    always_comb begin
        stallF = rst_n & (mem_wait | (~pcSrcE & lw_stall));
        stallD = stallF;
        stallE = rst_n & mem_wait;
        stallM = stallE;
        flushW = stallE;
        flushD = rst_n & ~mem_wait & pcSrcE;
        flushE = rst_n & ~mem_wait & (pcSrcE | lw_stall);
    end

    assign any_stall = stallF | stallD | stallE | stallM;
    assign any_flush = flushD | flushE;

    forwarding_unit u_fwd_a (
        .rsE(rs1E), .rdM(rdM), .regWriteM(regWriteM),
        .rdW(rdW), .regWriteW(regWriteW), .fwd(fwd_a)
    );

    forwarding_unit u_fwd_b (
        .rsE(rs2E), .rdM(rdM), .regWriteM(regWriteM),
        .rdW(rdW), .regWriteW(regWriteW), .fwd(fwd_b)
    );

    assign forwardAE = rst_n ? fwd_a : FWD_RF;
    assign forwardBE = rst_n ? fwd_b : FWD_RF;

    always_comb begin
        state_nxt    = (state == RUN) ? (mem_wait ? MEM_WAIT : RUN)
                                      : ((memReadyM | ~memReqM) ? RUN : MEM_WAIT);
        wait_cnt_nxt = (state == RUN) ? '0 :
                       (mem_wait && wait_cnt != WW'(TIMEOUT)) ? wait_cnt + 1'b1 : wait_cnt;
    end

    // The watchdog latches in the same edge the wait counter hits its limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            memTimeout  <= 1'b0;
            stallCycles <= '0;
            flushEvents <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            memTimeout <= memTimeout | (wait_cnt_nxt == WW'(TIMEOUT));
            if (any_stall && !(&stallCycles))
                stallCycles <= stallCycles + 1'b1;
            if (any_flush && !(&flushEvents))
                flushEvents <= flushEvents + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed scoreboard bench for hazard_ctrl.
module tb_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic          memReadE, pcSrcE, regWriteM, memReqM, memReadyM, regWriteW;
    logic          stallF, stallD, stallE, stallM, flushD, flushE, flushW, memTimeout;
    logic [1:0]    forwardAE, forwardBE;
    logic [CW-1:0] stallCycles, flushEvents;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .memReadE(memReadE), .pcSrcE(pcSrcE), .rdM(rdM), .regWriteM(regWriteM),
        .memReqM(memReqM), .memReadyM(memReadyM), .rdW(rdW), .regWriteW(regWriteW),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .memTimeout(memTimeout),
        .stallCycles(stallCycles), .flushEvents(flushEvents)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0]   ctl;
        logic          to;
        logic [CW-1:0] sc;
        logic [CW-1:0] fe;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            streak;
    logic          m_to;
    logic [CW-1:0] m_sc, m_fe;

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (regWriteM && rdM != 0 && rdM == rs) return 2'b10;
        if (regWriteW && rdW != 0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
        {memReadE, pcSrcE, regWriteM, memReqM, memReadyM, regWriteW} = '0;
        memReadyM = 1'b1;
    endtask

    // Predict this cycle's outputs, queue them, then advance the model over the next edge.
    task automatic tick();
        exp_t e;
        logic mw, lw;
        logic [6:0] sf;
        if (!rst_n) begin
            streak = 0; m_to = 0; m_sc = '0; m_fe = '0;
        end
        mw = memReqM && !memReadyM;
        lw = memReadE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
        if (!rst_n)      sf = 7'b0000000;
        else if (mw)     sf = 7'b1111001;
        else if (pcSrcE) sf = 7'b0000110;
        else if (lw)     sf = 7'b1100010;
        else             sf = 7'b0000000;
        e.ctl = {sf, rst_n ? fwd_ref(rs1E) : 2'b00, rst_n ? fwd_ref(rs2E) : 2'b00};
        e.to = m_to;
        e.sc = m_sc;
        e.fe = m_fe;
        q.push_back(e);
        if (rst_n) begin
            if (sf[6:3] != 0 && m_sc != '1) m_sc = m_sc + 1'b1;
            if (sf[2:1] != 0 && m_fe != '1) m_fe = m_fe + 1'b1;
            streak = mw ? streak + 1 : 0;
            if (streak >= TO + 1) m_to = 1'b1;
        end
        @(negedge clk);
    endtask

    always begin
        exp_t e;
        logic [10:0] act;
        @(negedge clk);
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, forwardAE, forwardBE};
            checks += 4;
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL ctl t=%0t got %b want %b", $time, act, e.ctl);
            end
            if (memTimeout !== e.to) begin
                errors++;
                $display("FAIL memTimeout t=%0t got %b want %b", $time, memTimeout, e.to);
            end
            if (stallCycles !== e.sc) begin
                errors++;
                $display("FAIL stallCycles t=%0t got %0d want %0d", $time, stallCycles, e.sc);
            end
            if (flushEvents !== e.fe) begin
                errors++;
                $display("FAIL flushEvents t=%0t got %0d want %0d", $time, flushEvents, e.fe);
            end
        end
    end

    initial begin
        idle();
        memReqM = 1; memReadyM = 0; pcSrcE = 1;
        rst_n = 0;
        @(negedge clk);
        repeat (2) tick();
        idle(); rst_n = 1; tick();
        memReadE = 1; rdE = 5; rs1D = 5; tick();
        idle(); tick();
        memReadE = 1; rdE = 0; rs1D = 0; tick();
        idle(); pcSrcE = 1; tick();
        idle(); pcSrcE = 1; memReadE = 1; rdE = 3; rs2D = 3; tick();
        idle(); rs1E = 7; rs2E = 7; rdM = 7; regWriteM = 1; rdW = 7; regWriteW = 1; tick();
        regWriteM = 0; tick();
        rdW = 0; tick();
        idle(); memReqM = 1; memReadyM = 0;
        repeat (3) tick();
        memReadyM = 1; tick();
        idle(); repeat (2) tick();
        memReqM = 1; memReadyM = 0;
        repeat (8) tick();
        memReadyM = 1; repeat (2) tick();
        idle(); repeat (2) tick();
        memReqM = 1; memReadyM = 0; repeat (3) tick();
        rst_n = 0; tick();
        rst_n = 1; idle(); repeat (2) tick();
        for (int i = 0; i < 1500; i++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            rs1D      = 5'($urandom_range(0, 3));
            rs2D      = 5'($urandom_range(0, 3));
            rs1E      = 5'($urandom_range(0, 3));
            rs2E      = 5'($urandom_range(0, 3));
            rdE       = 5'($urandom_range(0, 3));
            rdM       = 5'($urandom_range(0, 3));
            rdW       = 5'($urandom_range(0, 3));
            memReadE  = ($urandom_range(0, 3) == 0);
            pcSrcE    = ($urandom_range(0, 5) == 0);
            regWriteM = $urandom_range(0, 1) != 0;
            regWriteW = $urandom_range(0, 1) != 0;
            memReqM   = $urandom_range(0, 1) != 0;
            memReadyM = ($urandom_range(0, 2) == 0);
            tick();
        end
        idle();
        rst_n = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
